// File: rtl/program_sequencer.sv
// Fetch program sequencer: registered PC with inc/jump/branch and
// call/return through a hardware return-address stack.
//
// Ports:
//   clk, arst_n    rising-edge clock, asynchronous active-low reset
//   flash_ready    qualifies every state update, including err_clr
//   pc_op          000 HOLD, 001 INC, 010 JUMP, 011 BRANCH,
//                  100 CALL, 101 RET, 11x HOLD
//   pc_target      absolute target for JUMP/CALL
//   pc_offset      signed offset for BRANCH, relative to pc_out
//   err_clr        clears the sticky stack error
//   pc_out         current fetch address (registered)
//   bootstrapping  pc_out < BOOT_LIMIT
//   stack_depth    valid return-address entries
//   stack_empty    stack_depth == 0
//   stack_full     stack_depth == STACK_DEPTH
//   stack_err      sticky overflow/underflow flag
module program_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned OFF_WIDTH = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned BOOT_LIMIT = 'h200,
    parameter int unsigned SP_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flash_ready,
    input  logic [2:0]            pc_op,
    input  logic [ADDR_WIDTH-1:0] pc_target,
    input  logic [OFF_WIDTH-1:0]  pc_offset,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  bootstrapping,
    output logic [SP_WIDTH-1:0]   stack_depth,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_err
);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;

    // Index width for the entry array; rounded up so a 1-deep
    // stack still gets a legal 1-bit index.
    localparam int unsigned IDX_W =
        (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned MEM_N = 1 << IDX_W;

    if (OFF_WIDTH > ADDR_WIDTH) begin : g_chk_off
        $error("OFF_WIDTH must not exceed ADDR_WIDTH");
    end
    if (STACK_DEPTH < 1) begin : g_chk_depth
        $error("STACK_DEPTH must be at least 1");
    end
    if (ADDR_WIDTH > 32) begin : g_chk_addr
        $error("ADDR_WIDTH above 32 is not supported");
    end

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [SP_WIDTH-1:0]   sp_q;
    logic [SP_WIDTH-1:0]   sp_nxt;
    logic                  err_q;
    logic                  err_nxt;
    logic                  push;

    logic [ADDR_WIDTH-1:0] mem [MEM_N];

    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_br;
    logic [ADDR_WIDTH-1:0] off_ext;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [ADDR_WIDTH-1:0] top;

    logic do_inc;
    logic do_jump;
    logic do_branch;
    logic do_call;
    logic do_ret;

    assign full  = (sp_q == SP_WIDTH'(STACK_DEPTH));
    assign empty = (sp_q == '0);

    // Sizing a signed value sign-extends it; arithmetic then
    // wraps naturally at ADDR_WIDTH bits.
    assign off_ext = ADDR_WIDTH'($signed(pc_offset));
    assign pc_inc  = pc_q + ADDR_WIDTH'(1);
    assign pc_br   = pc_q + off_ext;

    // Push writes slot sp, pop reads slot sp-1.  rd_idx wraps
    // when empty, but top is only used when a RET is legal.
    assign wr_idx = IDX_W'(sp_q);
    assign rd_idx = IDX_W'(sp_q - SP_WIDTH'(1));
    assign top    = mem[rd_idx];

    assign do_inc    = flash_ready && (pc_op == OP_INC);
    assign do_jump   = flash_ready && (pc_op == OP_JUMP);
    assign do_branch = flash_ready && (pc_op == OP_BRANCH);
    assign do_call   = flash_ready && (pc_op == OP_CALL);
    assign do_ret    = flash_ready && (pc_op == OP_RET);

    always_comb begin
        pc_nxt  = pc_q;
        sp_nxt  = sp_q;
        err_nxt = err_q;
        push    = 1'b0;

        // Clear first so a same-cycle overflow/underflow set wins.
        if (flash_ready && err_clr) begin
            err_nxt = 1'b0;
        end

        unique case (1'b1)
            do_inc: begin
                pc_nxt = pc_inc;
            end
            do_jump: begin
                pc_nxt = pc_target;
            end
            do_branch: begin
                pc_nxt = pc_br;
            end
            do_call: begin
                if (full) begin
                    err_nxt = 1'b1;
                end else begin
                    push   = 1'b1;
                    sp_nxt = sp_q + SP_WIDTH'(1);
                    pc_nxt = pc_target;
                end
            end
            do_ret: begin
                if (empty) begin
                    err_nxt = 1'b1;
                end else begin
                    sp_nxt = sp_q - SP_WIDTH'(1);
                    pc_nxt = top;
                end
            end
            default: begin
                pc_nxt = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            sp_q  <= sp_nxt;
            err_q <= err_nxt;
        end
    end

    // Entries need no reset: sp gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= pc_inc;
        end
    end

    assign pc_out        = pc_q;
    assign bootstrapping = (32'(pc_q) < BOOT_LIMIT);
    assign stack_depth   = sp_q;
    assign stack_empty   = empty;
    assign stack_full    = full;
    assign stack_err     = err_q;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the fetch program counter. Adds selectable reset vector and boot-region limit.
- Adds signed relative branch, plus call/return through an internal hardware return-address stack (LIFO).
- Sits between the instruction decoder (drives pc_op) and the flash fetch port (consumes pc_out). All PC updates are gated by flash_ready.

Parameters:
- ADDR_WIDTH, 12, width of PC and all addresses.
- OFF_WIDTH, 8, width of signed relative branch offset (two's complement); must be ≤ ADDR_WIDTH.
- STACK_DEPTH, 4, number of return-address entries (≥ 1).
- RESET_VECTOR, 0, PC value after reset.
- BOOT_LIMIT, 'h200, first address outside the bootstrap region.
- SP_WIDTH, $clog2(STACK_DEPTH+1), derived, width of the depth counter.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- flash_ready  in  1  fetch port ready; PC, stack and error state change only when 1.
- pc_op  in  3  operation: 000 HOLD, 001 INC, 010 JUMP, 011 BRANCH, 100 CALL, 101 RET, 11x HOLD.
- pc_target  in  ADDR_WIDTH  absolute target for JUMP/CALL.
- pc_offset  in  OFF_WIDTH  signed offset for BRANCH.
- err_clr  in  1  clears stack_err.
- pc_out  out  ADDR_WIDTH  current fetch address (registered).
- bootstrapping  out  1  pc_out < BOOT_LIMIT, combinational from pc_out.
- stack_depth  out  SP_WIDTH  number of valid stack entries.
- stack_empty  out  1  stack_depth == 0.
- stack_full  out  1  stack_depth == STACK_DEPTH.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: arst_n, asynchronous, active-low; clock clk.
  - On reset: pc_out = RESET_VECTOR, stack_depth = 0, stack_err = 0.
  - Stack entry contents after reset are don't-care, but must never appear on pc_out.
- Update rule: if flash_ready = 0, all state holds regardless of pc_op; err_clr is also ignored. Otherwise, on the clock edge:
  - INC: pc_out ← pc_out + 1, modulo 2^ADDR_WIDTH; all-ones wraps to 0.
  - JUMP: pc_out ← pc_target.
  - BRANCH: pc_out ← pc_out + sign_extend(pc_offset), modulo 2^ADDR_WIDTH. The offset is relative to the current pc_out, not pc_out + 1.
  - CALL with stack not full: push (pc_out + 1) mod 2^ADDR_WIDTH, stack_depth + 1, pc_out ← pc_target.
  - CALL with stack full: no push, pc_out holds, stack_err ← 1.
  - RET with stack not empty: pc_out ← top entry, stack_depth − 1.
  - RET with stack empty: pc_out holds, stack_err ← 1.
  - HOLD / reserved codes: no change.
- Latency: one cycle. The new pc_out is visible the cycle after the accepted op; a single-cycle CALL/RET has no bubble.
- Back-to-back ops: CALL then RET on consecutive ready cycles returns to call address + 1. Nested calls unwind in LIFO order.
- err_clr:
  - Applied when flash_ready = 1.
  - If an overflow/underflow occurs in the same cycle, the set wins and stack_err stays 1.
  - err_clr does not affect pc_out or the stack.
- Status outputs: stack_full, stack_empty and bootstrapping are combinational from registered state; no glitch requirement beyond that.
- Mid-operation reset: asserting arst_n low at any time immediately forces the reset values. The stack is logically emptied.

Test Plan:
- Reset with RESET_VECTOR = 'h000, then 3 cycles INC with flash_ready = 1 → pc_out = 'h003, bootstrapping = 1.
- pc_op = INC with flash_ready = 0 for 5 cycles → pc_out unchanged; then JUMP target 'h1FF followed by INC → pc_out 'h1FF (bootstrapping = 1), then 'h200 (bootstrapping = 0).
- pc_out = 'h210, BRANCH offset 'hF0 (−16) → 'h200. Then pc_out = 'h005, BRANCH −8 → 'hFFD (wrap). Then pc_out = 'hFFF, INC → 'h000.
- CALL chain with STACK_DEPTH = 4: from 'h300 CALL 'h400, CALL 'h500, CALL 'h600, CALL 'h700 → depth 4, stack_full = 1. Four RETs → 'h701? No: returns are 'h601, 'h501, 'h401, 'h301 in that order; stack_empty = 1 at end.
- CALL while full → pc_out holds, depth stays 4, stack_err = 1. RET on empty → pc_out holds, stack_err = 1. err_clr together with an underflow → stack_err stays 1; err_clr alone → stack_err = 0.
- Two CALLs then assert arst_n low mid-cycle → pc_out = RESET_VECTOR and depth = 0 immediately; a following RET → stack_err = 1 and pc_out unchanged.
